// File: rtl/code_entry_sequencer_pkg.sv
// Shared types and helpers for the code entry sequencer.
// State encoding, digit width and a packed-code digit extractor.
package code_entry_pkg;

   localparam int DIGIT_W    = 3;
   localparam int MAX_DIGITS = 8;
   localparam int MAX_CODE_W = DIGIT_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTER    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_e;

   // Digit i of a packed code; digit 0 lives in bits [2:0].
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [MAX_CODE_W-1:0] code,
                                                    input int unsigned i);
      return code[i*DIGIT_W +: DIGIT_W];
   endfunction

endpackage

// File: rtl/code_entry_sequencer_timer.sv
// Loadable down-counter with a done flag (count == 0).
// load has priority over en; the count holds at zero.
module code_entry_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: reload, decrement while enabled, or hold.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/code_entry_sequencer.sv
// Code entry sequencer: collects NUM_DIGITS 3-bit digits, compares each
// against the stored code through an external equality checker (cmp_a/cmp_b
// out, cmp_eq back in the same cycle) and decides unlock, error or lockout.
// Optional inter-digit timeout in ENTER: define CODE_ENTRY_TIMEOUT_EN.
module code_entry_sequencer
   import code_entry_pkg::*;
#(
   parameter int                          NUM_DIGITS     = 4,
   parameter int                          MAX_TRIES      = 3,
   parameter int                          UNLOCK_CYCLES  = 8,
   parameter int                          LOCKOUT_CYCLES = 16,
   parameter logic [3*NUM_DIGITS-1:0]     RESET_CODE     = '0,
   parameter int                          TIMEOUT_CYCLES = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [2:0]                      digit_in,
   input  logic                            digit_valid,
   input  logic                            code_load,
   input  logic [3*NUM_DIGITS-1:0]         code_in,
   output logic [2:0]                      cmp_a,
   output logic [2:0]                      cmp_b,
   input  logic                            cmp_eq,
   output logic                            unlocked,
   output logic                            err,
   output logic                            locked_out,
   output logic [$clog2(NUM_DIGITS+1)-1:0] digit_idx
);

   localparam int IDX_W     = $clog2(NUM_DIGITS + 1);
   localparam int CODE_W    = DIGIT_W * NUM_DIGITS;
   localparam int FAIL_W    = 3;
   localparam int DWELL_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int DWELL_W   = $clog2(DWELL_MAX + 1);

   // Handshake: digit_valid and code_load are single-cycle strobes with no
   // back-pressure; they are consumed only in the states that honour them
   // and silently dropped everywhere else.

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic                mismatch_q, mismatch_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                err_q, err_d;
   logic                unlocked_q, unlocked_d;
   logic                locked_out_q, locked_out_d;

   logic                dwell_load, dwell_en, dwell_done;
   logic [DWELL_W-1:0]  dwell_val;
   logic                digit_accept;

   // Dwell timer for UNLOCKED and LOCKOUT.
   code_entry_timer #(.W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (dwell_load),
      .load_val (dwell_val),
      .en       (dwell_en),
      .done     (dwell_done)
   );

`ifdef CODE_ENTRY_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic to_done;

   // Inter-digit timeout: reloaded on each accepted digit, runs while ENTER sees no strobe.
   code_entry_timer #(.W(TO_W)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .load     (digit_accept),
      .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
      .en       ((state_q == ENTER) && !digit_valid),
      .done     (to_done)
   );
`endif

   // A digit is taken in IDLE/ENTER unless an IDLE code_load claims the cycle.
   assign digit_accept = digit_valid && !(state_q == IDLE && code_load) &&
                         ((state_q == IDLE) || (state_q == ENTER));

   // Next-state and registered-output logic for the sequencer FSM.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      fail_cnt_d   = fail_cnt_q;
      mismatch_d   = mismatch_q;
      code_d       = code_q;
      err_d        = 1'b0;
      unlocked_d   = unlocked_q;
      locked_out_d = locked_out_q;
      dwell_load   = 1'b0;
      dwell_val    = '0;
      dwell_en     = 1'b0;
      case (state_q)
         IDLE, ENTER: begin
            if (state_q == IDLE && code_load) begin
               code_d = code_in;
            end else if (digit_accept) begin
               if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                  idx_d      = '0;
                  mismatch_d = 1'b0;
                  if (!mismatch_q && cmp_eq) begin
                     state_d    = UNLOCKED;
                     fail_cnt_d = '0;
                     unlocked_d = 1'b1;
                     dwell_load = 1'b1;
                     dwell_val  = DWELL_W'(UNLOCK_CYCLES - 1);
                  end else begin
                     err_d = 1'b1;
                     if ((fail_cnt_q + FAIL_W'(1)) == FAIL_W'(MAX_TRIES)) begin
                        state_d      = LOCKOUT;
                        fail_cnt_d   = '0;
                        locked_out_d = 1'b1;
                        dwell_load   = 1'b1;
                        dwell_val    = DWELL_W'(LOCKOUT_CYCLES - 1);
                     end else begin
                        state_d    = IDLE;
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                     end
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ENTER;
                  if (!cmp_eq) begin
                     mismatch_d = 1'b1;
                  end
               end
            end
`ifdef CODE_ENTRY_TIMEOUT_EN
            else if (state_q == ENTER && to_done) begin
               state_d    = IDLE;
               idx_d      = '0;
               mismatch_d = 1'b0;
            end
`endif
         end
         UNLOCKED: begin
            if (dwell_done) begin
               state_d    = IDLE;
               unlocked_d = 1'b0;
            end else begin
               dwell_en = 1'b1;
            end
         end
         LOCKOUT: begin
            if (dwell_done) begin
               state_d      = IDLE;
               locked_out_d = 1'b0;
            end else begin
               dwell_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers; reset also restores the stored code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         fail_cnt_q   <= '0;
         mismatch_q   <= 1'b0;
         code_q       <= RESET_CODE;
         err_q        <= 1'b0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         fail_cnt_q   <= fail_cnt_d;
         mismatch_q   <= mismatch_d;
         code_q       <= code_d;
         err_q        <= err_d;
         unlocked_q   <= unlocked_d;
         locked_out_q <= locked_out_d;
      end
   end

   assign cmp_a      = digit_in;
   assign cmp_b      = ((state_q == UNLOCKED) || (state_q == LOCKOUT)) ?
                       get_digit(MAX_CODE_W'(code_q), 0) :
                       get_digit(MAX_CODE_W'(code_q), int'(idx_q));
   assign unlocked   = unlocked_q;
   assign err        = err_q;
   assign locked_out = locked_out_q;
   assign digit_idx  = idx_q;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Bench for code_entry_sequencer: directed attempts against a queue-based
// model of the entry rules, checked every cycle, plus literal expectations.
module tb_code_entry_sequencer;

   localparam int N  = 4;
   localparam int MT = 3;
   localparam int UC = 8;
   localparam int LC = 16;
   localparam int TC = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  digit_in = '0;
   logic        digit_valid = 1'b0;
   logic        code_load = 1'b0;
   logic [11:0] code_in = '0;
   logic [2:0]  cmp_a, cmp_b;
   logic        cmp_eq;
   logic        unlocked, err, locked_out;
   logic [2:0]  digit_idx;

   int checks = 0;
   int errors = 0;
   int unl_cnt = 0;
   int lck_cnt = 0;
   int err_cnt = 0;

   // Clock
   always #5 clk = ~clk;

   // External equality checker
   assign cmp_eq = (cmp_a == cmp_b);

   code_entry_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .code_load   (code_load),
      .code_in     (code_in),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_eq      (cmp_eq),
      .unlocked    (unlocked),
      .err         (err),
      .locked_out  (locked_out),
      .digit_idx   (digit_idx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: mode 0 = accepting digits, 1 = unlocked, 2 = locked out.
   int          m_mode = 0;
   logic [2:0]  m_entered[$];
   int          m_rem = 0;
   int          m_fail = 0;
   int          m_idle = 0;
   logic        m_err = 1'b0;
   logic [11:0] m_code = '0;
   logic        m_ok;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0;
         m_entered.delete();
         m_rem = 0;
         m_fail = 0;
         m_idle = 0;
         m_err = 1'b0;
         m_code = '0;
      end else begin
         m_err = 1'b0;
         if (m_mode != 0) begin
            if (m_rem == 1) m_mode = 0;
            else m_rem--;
         end else if (code_load && m_entered.size() == 0) begin
            m_code = code_in;
         end else if (digit_valid) begin
            m_entered.push_back(digit_in);
            m_idle = 0;
            if (m_entered.size() == N) begin
               m_ok = 1'b1;
               for (int i = 0; i < N; i++)
                  if (m_entered[i] !== m_code[i*3 +: 3]) m_ok = 1'b0;
               m_entered.delete();
               if (m_ok) begin
                  m_mode = 1;
                  m_rem = UC;
                  m_fail = 0;
               end else begin
                  m_err = 1'b1;
                  m_fail++;
                  if (m_fail == MT) begin
                     m_mode = 2;
                     m_rem = LC;
                     m_fail = 0;
                  end
               end
            end
         end
`ifdef CODE_ENTRY_TIMEOUT_EN
         else if (m_entered.size() != 0) begin
            m_idle++;
            if (m_idle == TC) begin
               m_entered.delete();
               m_idle = 0;
            end
         end
`endif
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("unlocked", unlocked, (m_mode == 1));
      check("locked_out", locked_out, (m_mode == 2));
      check("err", err, m_err);
      check("digit_idx", digit_idx, m_entered.size());
      check("cmp_a", cmp_a, digit_in);
      check("cmp_b", cmp_b, (m_mode != 0) ? m_code[2:0] : m_code[m_entered.size()*3 +: 3]);
      if (unlocked) unl_cnt++;
      if (locked_out) lck_cnt++;
      if (err) err_cnt++;
   end

   // Driver tasks
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic drive_digit(input logic [2:0] d);
      digit_in = d;
      digit_valid = 1'b1;
      cyc();
      digit_valid = 1'b0;
   endtask

   task automatic enter_code(input logic [2:0] d0, input logic [2:0] d1,
                             input logic [2:0] d2, input logic [2:0] d3);
      drive_digit(d0);
      drive_digit(d1);
      drive_digit(d2);
      drive_digit(d3);
   endtask

   task automatic load_code(input logic [11:0] c);
      code_in = c;
      code_load = 1'b1;
      cyc();
      code_load = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && (unlocked || locked_out); i++) cyc();
      check("wait_idle", unlocked | locked_out, 0);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      rst = 1'b1;
      idle(3);
      check("reset_unlocked", unlocked, 0);
      check("reset_idx", digit_idx, 0);
      rst = 1'b0;
      idle(2);

      // Unlock with the reset code.
      unl_cnt = 0;
      err_cnt = 0;
      enter_code(0, 0, 0, 0);
      check("t1_unlocked", unlocked, 1);
      wait_idle();
      check("t1_unlock_len", unl_cnt, UC);
      check("t1_no_err", err_cnt, 0);

      // Wrong attempt after loading 5,6,2,3.
      err_cnt = 0;
      load_code(12'h6B5);
      check("t2_cmp_b0", cmp_b, 5);
      drive_digit(5);
      check("t2_idx1", digit_idx, 1);
      drive_digit(6);
      check("t2_idx2", digit_idx, 2);
      drive_digit(2);
      check("t2_idx3", digit_idx, 3);
      drive_digit(4);
      check("t2_idx0", digit_idx, 0);
      check("t2_err", err, 1);
      idle(1);
      check("t2_err_once", err, 0);

      // Two more failures reach the try limit.
      enter_code(0, 0, 0, 0);
      check("t3_not_locked", locked_out, 0);
      idle(1);
      lck_cnt = 0;
      enter_code(7, 7, 7, 7);
      check("t3_err", err, 1);
      check("t3_locked", locked_out, 1);
      drive_digit(5);
      drive_digit(6);
      load_code(12'h000);
      check("t3_ignore_idx", digit_idx, 0);
      wait_idle();
      check("t3_lock_len", lck_cnt, LC);
      check("t3_err_total", err_cnt, 3);
      enter_code(5, 6, 2, 3);
      check("t3_unlock", unlocked, 1);
      wait_idle();

      // code_load wins over a simultaneous digit; code_load in ENTER is ignored.
      code_in = 12'h8D1;
      code_load = 1'b1;
      digit_in = 1;
      digit_valid = 1'b1;
      cyc();
      code_load = 1'b0;
      digit_valid = 1'b0;
      check("t4_dropped", digit_idx, 0);
      check("t4_cmp_b0", cmp_b, 1);
      drive_digit(1);
      drive_digit(2);
      load_code(12'h000);
      check("t4_enter_idx", digit_idx, 2);
      drive_digit(3);
      drive_digit(4);
      check("t4_unlock", unlocked, 1);
      wait_idle();

      // Asynchronous reset mid-attempt restores the reset code.
      load_code(12'h6B5);
      drive_digit(5);
      drive_digit(6);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_idx", digit_idx, 0);
      check("t5_rst_unl", unlocked, 0);
      check("t5_rst_lock", locked_out, 0);
      check("t5_rst_err", err, 0);
      check("t5_rst_cmp_b", cmp_b, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      enter_code(0, 0, 0, 0);
      check("t5_unlock", unlocked, 1);
      wait_idle();

      // Two digits then a long pause.
      err_cnt = 0;
      drive_digit(3);
      drive_digit(3);
      idle(40);
`ifdef CODE_ENTRY_TIMEOUT_EN
      check("t6_timeout_idx", digit_idx, 0);
`else
      check("t6_wait_idx", digit_idx, 2);
`endif
      check("t6_no_err", err_cnt, 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
